// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues one word request at a
// time to instruction memory, and buffers {pc, instr} pairs in a small FIFO
// drained by the IF/ID register. Redirects flush the FIFO and discard any
// response still in flight.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  input  logic                    imem_ack,
  input  logic [31:0]             imem_rdata,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  input  logic                    deq_ready,
  output logic                    deq_valid,
  output logic [31:0]             deq_pc,
  output logic [31:0]             deq_instr,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Bit 0 of the encoding is the request strobe, so imem_req comes straight
  // off a flop with no decode logic in front of the memory interface.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DROP = 2'b11
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   stale_addr_q, stale_addr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] count_next;
  entry_t        mem_q [DEPTH];

  logic          enq;
  logic          deq;
  logic [31:0]   redirect_aligned;

  // Transfer qualifiers: a redirect blocks both sides of the FIFO.
  assign enq              = (state_q == REQ) && imem_ack && !redirect;
  assign deq              = (count_q != '0) && deq_ready && !redirect;
  assign count_next       = count_q + CW'(enq) - CW'(deq);
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  // Outputs: while dropping a stale request the old address must stay on the
  // bus even though fetch_pc already points at the redirect target.
  assign imem_req  = state_q[0];
  assign imem_addr = (state_q == DROP) ? stale_addr_q : fetch_pc_q;
  assign deq_valid = (count_q != '0) && !redirect;
  assign deq_pc    = (count_q != '0) ? mem_q[rd_ptr_q].pc    : '0;
  assign deq_instr = (count_q != '0) ? mem_q[rd_ptr_q].instr : '0;
  assign count     = count_q;

  // Next-state logic for the fetch FSM, PC and FIFO pointers.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    stale_addr_d = stale_addr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_next;

    if (enq) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      fetch_pc_d = fetch_pc_q + 32'd4;  // wraps at 2^32 silently
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (redirect) begin
      fetch_pc_d = redirect_aligned;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (!redirect && (count_next < DEPTH_C)) state_d = REQ;
      end
      REQ: begin
        if (redirect) begin
          // Unacked request must complete at its original address.
          if (!imem_ack) begin
            state_d      = DROP;
            stale_addr_d = fetch_pc_q;
          end
        end else if (imem_ack && (count_next >= DEPTH_C)) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        if (imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      stale_addr_q <= RESET_PC;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      stale_addr_q <= stale_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage write port.
  // NOTE: storage is not reset; the outputs are masked to zero while count is 0.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= '{pc: imem_addr, instr: imem_rdata};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, RESET_PC=0) with a variable-latency
// instruction memory responder and an overflow monitor.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;
  int ovf_hits = 0;

  // Memory model controls.
  logic resp_ack;
  logic force_ack;
  logic mem_en;
  int   ack_lat;
  int   wait_cnt;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_pc(deq_pc), .deq_instr(deq_instr), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_ack = resp_ack | force_ack;

  // Memory responder: acks on the ack_lat-th cycle a request has been held.
  always @(negedge clk) begin
    if (!imem_req) begin
      wait_cnt = 0;
      resp_ack = 1'b0;
    end else begin
      wait_cnt = imem_ack ? 1 : wait_cnt + 1;
      resp_ack = mem_en && (wait_cnt >= ack_lat);
    end
    imem_rdata = instr_of(imem_addr);
  end

  // An ack must never arrive while the FIFO is full.
  always @(posedge clk) begin
    if (!rst && imem_req && imem_ack && !redirect && count == 3'(DEPTH)) begin
      $display("FAIL overflow: ack with count=%0d", count);
      ovf_hits++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
    force_ack = 1'b0; mem_en = 1'b1; ack_lat = 1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    tick();
    total++; if (imem_req !== 1'b0) begin $display("FAIL rst_req got=%b exp=0", imem_req); bad++; end
    total++; if (imem_addr !== 32'h0) begin $display("FAIL rst_addr got=%h exp=0", imem_addr); bad++; end
    total++; if (deq_valid !== 1'b0) begin $display("FAIL rst_valid got=%b exp=0", deq_valid); bad++; end
    total++; if (deq_pc !== 32'h0) begin $display("FAIL rst_pc got=%h exp=0", deq_pc); bad++; end
    total++; if (deq_instr !== 32'h0) begin $display("FAIL rst_instr got=%h exp=0", deq_instr); bad++; end
    total++; if (count !== 3'd0) begin $display("FAIL rst_count got=%0d exp=0", count); bad++; end
  endtask

  task automatic test_stream();
    do_reset();
    deq_ready = 1'b1; rst = 1'b0;
    tick();  // first request visible
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      $display("FAIL stream_first got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); bad++; end
    for (int k = 2; k <= 7; k++) begin
      tick();
      total++; if (imem_addr !== 32'(4 * (k - 1))) begin
        $display("FAIL stream_addr got=%h exp=%h", imem_addr, 32'(4 * (k - 1))); bad++; end
      total++; if (deq_valid !== 1'b1 || deq_pc !== 32'(4 * (k - 2)) || deq_instr !== instr_of(32'(4 * (k - 2)))) begin
        $display("FAIL stream_deq got v=%b pc=%h ins=%h exp pc=%h", deq_valid, deq_pc, deq_instr, 32'(4 * (k - 2))); bad++; end
      total++; if (count !== 3'd1) begin $display("FAIL stream_count got=%0d exp=1", count); bad++; end
    end
  endtask

  task automatic test_full();
    do_reset();
    rst = 1'b0;
    repeat (4) tick();
    total++; if (count !== 3'd3 || imem_req !== 1'b1) begin
      $display("FAIL full_pre got count=%0d req=%b exp 3/1", count, imem_req); bad++; end
    tick();
    total++; if (count !== 3'd4 || imem_req !== 1'b0) begin
      $display("FAIL full_stop got count=%0d req=%b exp 4/0", count, imem_req); bad++; end
    tick();
    tick();
    total++; if (count !== 3'd4 || imem_req !== 1'b0 || deq_pc !== 32'h0) begin
      $display("FAIL full_hold got count=%0d req=%b pc=%h exp 4/0/0", count, imem_req, deq_pc); bad++; end
    deq_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++; if (deq_valid !== 1'b1 || deq_pc !== 32'(4 * i) || deq_instr !== instr_of(32'(4 * i))) begin
        $display("FAIL full_drain got v=%b pc=%h exp pc=%h", deq_valid, deq_pc, 32'(4 * i)); bad++; end
      if (i == 1) begin
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || count !== 3'd3) begin
          $display("FAIL full_resume got req=%b addr=%h count=%0d exp 1/10/3", imem_req, imem_addr, count); bad++; end
      end
      tick();
    end
  endtask

  task automatic test_drop();
    int waited;
    do_reset();
    ack_lat = 3; deq_ready = 1'b1; rst = 1'b0;
    tick();
    tick();  // second wait cycle
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    #1;
    total++; if (deq_valid !== 1'b0) begin $display("FAIL drop_valid got=%b exp=0", deq_valid); bad++; end
    tick();
    redirect = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || count !== 3'd0) begin
      $display("FAIL drop_hold got req=%b addr=%h count=%0d exp 1/0/0", imem_req, imem_addr, count); bad++; end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || count !== 3'd0 || deq_valid !== 1'b0) begin
      $display("FAIL drop_reissue got req=%b addr=%h count=%0d v=%b exp 1/40/0/0", imem_req, imem_addr, count, deq_valid); bad++; end
    waited = 0;
    while (!deq_valid && waited < 10) begin tick(); waited++; end
    total++; if (waited !== 3) begin $display("FAIL drop_latency got=%0d exp=3", waited); bad++; end
    total++; if (deq_pc !== 32'h40 || deq_instr !== instr_of(32'h40)) begin
      $display("FAIL drop_first got pc=%h ins=%h exp pc=40", deq_pc, deq_instr); bad++; end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    rst = 1'b0;
    repeat (3) tick();  // count=2, ack for 0x8 pending
    redirect = 1'b1; redirect_pc = 32'h0000_0103; deq_ready = 1'b1;
    #1;
    total++; if (deq_valid !== 1'b0 || count !== 3'd2) begin
      $display("FAIL rack_same got v=%b count=%0d exp 0/2", deq_valid, count); bad++; end
    tick();
    redirect = 1'b0;
    total++; if (count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 32'h100 || deq_valid !== 1'b0) begin
      $display("FAIL rack_next got count=%0d req=%b addr=%h v=%b exp 0/1/100/0", count, imem_req, imem_addr, deq_valid); bad++; end
    tick();
    total++; if (deq_valid !== 1'b1 || deq_pc !== 32'h100 || deq_instr !== instr_of(32'h100)) begin
      $display("FAIL rack_deq got v=%b pc=%h exp pc=100", deq_valid, deq_pc); bad++; end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    int idx;
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    do_reset();
    deq_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; rst = 1'b0;
    tick();
    redirect = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFF8 || imem_req !== 1'b0) begin
      $display("FAIL wrap_idle got addr=%h req=%b exp FFFFFFF8/0", imem_addr, imem_req); bad++; end
    idx = 0;
    for (int c = 0; c < 12 && idx < 3; c++) begin
      tick();
      if (deq_valid) begin
        total++; if (deq_pc !== exp_pc[idx] || deq_instr !== instr_of(exp_pc[idx])) begin
          $display("FAIL wrap_pc got=%h exp=%h", deq_pc, exp_pc[idx]); bad++; end
        idx++;
      end
    end
    total++; if (idx !== 3) begin $display("FAIL wrap_timeout got=%0d exp=3", idx); bad++; end
  endtask

  task automatic test_reset_mid();
    int waited;
    do_reset();
    rst = 1'b0;
    repeat (3) tick();
    mem_en = 1'b0;
    tick();
    total++; if (count !== 3'd3 || imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      $display("FAIL rmid_pre got count=%0d req=%b addr=%h exp 3/1/C", count, imem_req, imem_addr); bad++; end
    #2 rst = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || count !== 3'd0) begin
      $display("FAIL rmid_async got req=%b addr=%h count=%0d exp 0/0/0", imem_req, imem_addr, count); bad++; end
    total++; if (deq_valid !== 1'b0 || deq_pc !== 32'h0 || deq_instr !== 32'h0) begin
      $display("FAIL rmid_deq got v=%b pc=%h ins=%h exp 0/0/0", deq_valid, deq_pc, deq_instr); bad++; end
    tick();
    force_ack = 1'b1; deq_ready = 1'b1; rst = 1'b0;
    tick();
    force_ack = 1'b0;
    total++; if (count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 32'h0 || deq_valid !== 1'b0) begin
      $display("FAIL rmid_late got count=%0d req=%b addr=%h v=%b exp 0/1/0/0", count, imem_req, imem_addr, deq_valid); bad++; end
    mem_en = 1'b1;
    waited = 0;
    while (!deq_valid && waited < 10) begin tick(); waited++; end
    total++; if (deq_valid !== 1'b1 || deq_pc !== 32'h0 || deq_instr !== instr_of(32'h0)) begin
      $display("FAIL rmid_first got v=%b pc=%h exp pc=0", deq_valid, deq_pc); bad++; end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
    force_ack = 1'b0; mem_en = 1'b1; ack_lat = 1; resp_ack = 1'b0; wait_cnt = 0;
    test_reset();
    test_stream();
    test_full();
    test_drop();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    total++; if (ovf_hits !== 0) begin $display("FAIL overflow_hits got=%0d exp=0", ovf_hits); bad++; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
